// File: rtl/fpu_mac_seq.sv
// Multiply-accumulate sequencer driving non-pipelined float32 multiplier and adder cores.
// Optional macro FPU_MAC_RELU_EN clamps negative results to +0 at the output.
module fpu_mac_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_last,
  input  logic             in_stb,
  output logic             in_ack,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_a_stb,
  output logic             mul_b_stb,
  input  logic             mul_a_ack,
  input  logic             mul_b_ack,
  input  logic [31:0]      mul_z,
  input  logic             mul_z_stb,
  output logic             mul_z_ack,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_a_stb,
  output logic             add_b_stb,
  input  logic             add_a_ack,
  input  logic             add_b_ack,
  input  logic [31:0]      add_z,
  input  logic             add_z_stb,
  output logic             add_z_ack,
  output logic [31:0]      out_z,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_z_stb,
  input  logic             out_z_ack
);

  typedef enum logic [2:0] {
    GET_IN,
    MUL_PUT,
    MUL_GET,
    ADD_PUT,
    ADD_GET,
    PUT_OUT
  } state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic             last;

  // An operand channel is done once its stb has dropped or is dropping on this edge.
  logic mul_a_done, mul_b_done, add_a_done, add_b_done;
  assign mul_a_done = !mul_a_stb || mul_a_ack;
  assign mul_b_done = !mul_b_stb || mul_b_ack;
  assign add_a_done = !add_a_stb || add_a_ack;
  assign add_b_done = !add_b_stb || add_b_ack;

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef FPU_MAC_RELU_EN
    return v[31] ? 32'h0000_0000 : v;
`else
    return v;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= GET_IN;
      in_ack    <= 1'b0;
      mul_a_stb <= 1'b0;
      mul_b_stb <= 1'b0;
      mul_z_ack <= 1'b0;
      add_a_stb <= 1'b0;
      add_b_stb <= 1'b0;
      add_z_ack <= 1'b0;
      out_z_stb <= 1'b0;
      out_z     <= 32'h0000_0000;
      out_cnt   <= '0;
      acc       <= 32'h0000_0000;
      cnt       <= '0;
      last      <= 1'b0;
    end else begin
      case (state)
        GET_IN: begin
          in_ack <= 1'b1;
          if (in_stb && in_ack) begin
            in_ack    <= 1'b0;
            mul_a     <= in_a;
            mul_b     <= in_b;
            last      <= in_last;
            mul_a_stb <= 1'b1;
            mul_b_stb <= 1'b1;
            state     <= MUL_PUT;
          end
        end
        MUL_PUT: begin
          if (mul_a_stb && mul_a_ack) mul_a_stb <= 1'b0;
          if (mul_b_stb && mul_b_ack) mul_b_stb <= 1'b0;
          if (mul_a_done && mul_b_done) begin
            mul_z_ack <= 1'b1;
            state     <= MUL_GET;
          end
        end
        MUL_GET: begin
          if (mul_z_stb && mul_z_ack) begin
            mul_z_ack <= 1'b0;
            add_a     <= acc;
            add_b     <= mul_z;
            add_a_stb <= 1'b1;
            add_b_stb <= 1'b1;
            state     <= ADD_PUT;
          end
        end
        ADD_PUT: begin
          if (add_a_stb && add_a_ack) add_a_stb <= 1'b0;
          if (add_b_stb && add_b_ack) add_b_stb <= 1'b0;
          if (add_a_done && add_b_done) begin
            add_z_ack <= 1'b1;
            state     <= ADD_GET;
          end
        end
        ADD_GET: begin
          if (add_z_stb && add_z_ack) begin
            add_z_ack <= 1'b0;
            acc       <= add_z;
            cnt       <= cnt + 1'b1;
            if (last) begin
              out_z     <= relu(add_z);
              out_cnt   <= cnt + 1'b1;
              out_z_stb <= 1'b1;
              state     <= PUT_OUT;
            end else begin
              in_ack <= 1'b1;
              state  <= GET_IN;
            end
          end
        end
        PUT_OUT: begin
          // Accumulator restarts from +0 for the next vector once the result is taken.
          if (out_z_stb && out_z_ack) begin
            out_z_stb <= 1'b0;
            acc       <= 32'h0000_0000;
            cnt       <= '0;
            in_ack    <= 1'b1;
            state     <= GET_IN;
          end
        end
        default: state <= GET_IN;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mac_seq.sv
// Bench for fpu_mac_seq: behavioural float32 stub cores, directed cases and random dot products.
module tb_fpu_mac_seq;
  localparam int CNT_W = 16;

  logic             clk, rst;
  logic [31:0]      in_a, in_b;
  logic             in_last, in_stb, in_ack;
  logic [31:0]      mul_a, mul_b, mul_z;
  logic             mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack;
  logic [31:0]      add_a, add_b, add_z;
  logic             add_a_stb, add_b_stb, add_a_ack, add_b_ack, add_z_stb, add_z_ack;
  logic [31:0]      out_z;
  logic [CNT_W-1:0] out_cnt;
  logic             out_z_stb, out_z_ack;

  fpu_mac_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_stb(in_stb), .in_ack(in_ack),
    .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
    .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
    .add_a_ack(add_a_ack), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
    .out_z(out_z), .out_cnt(out_cnt), .out_z_stb(out_z_stb), .out_z_ack(out_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int mul_da = 0, mul_db = 0, mul_dz = 0, add_da = 0, add_db = 0, add_dz = 0;
  int n_mul_fetch = 0, n_pulse = 0, pulse_mark = 0, cyc = 0, a_fall = 0, b_fall = 0;
  logic [31:0] qa[$], qb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // float32 <-> real for normal numbers and signed zero.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:23] == 8'd0) d = {f[31], 63'd0};
    else begin
      e = {3'b000, f[30:23]} + 11'd896;
      d = {f[31], e, f[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [24:0] m;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    m = {2'b01, d[51:29]};
    if (d[28] && ((d[27:0] != 28'd0) || d[29])) m = m + 25'd1;
    e = d[62:52] - 11'd896;
    if (m[24]) begin
      m = m >> 1;
      e = e + 11'd1;
    end
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) * f2r(y));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) + f2r(y));
  endfunction

  function automatic logic [31:0] relu_ref(input logic [31:0] v);
`ifdef FPU_MAC_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: sequential float32 dot product starting from +0.
  function automatic logic [31:0] ref_dot(input logic [31:0] va[$], input logic [31:0] vb[$]);
    logic [31:0] acc;
    acc = 32'h0;
    foreach (va[i]) acc = fadd(acc, fmul(va[i], vb[i]));
    return relu_ref(acc);
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [31:0] r;
    r[31]    = 1'($urandom_range(0, 1));
    r[30:23] = 8'($urandom_range(124, 130));
    r[22:0]  = 23'($urandom);
    return r;
  endfunction

  // Multiplier stub: steps #1 after each edge, acks after programmable delays.
  initial begin : mul_core
    logic pa_stb, pb_stb, pz_ack, ga, gb;
    logic [31:0] pa, pb, ra, rb;
    int wa, wb, wz;
    mul_a_ack = 0; mul_b_ack = 0; mul_z_stb = 0; mul_z = 0;
    pa_stb = 0; pb_stb = 0; pz_ack = 0; ga = 0; gb = 0;
    pa = 0; pb = 0; ra = 0; rb = 0; wa = 0; wb = 0; wz = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mul_a_ack = 0; mul_b_ack = 0; mul_z_stb = 0; ga = 0; gb = 0; wa = 0; wb = 0; wz = 0;
      end else begin
        if (mul_a_ack && pa_stb) begin mul_a_ack = 0; ga = 1; ra = pa; end
        if (mul_b_ack && pb_stb) begin mul_b_ack = 0; gb = 1; rb = pb; end
        if (mul_z_stb && pz_ack) begin mul_z_stb = 0; ga = 0; gb = 0; wz = 0; n_mul_fetch++; end
        if (!ga && !mul_a_ack && mul_a_stb) begin
          if (wa >= mul_da) begin mul_a_ack = 1; wa = 0; end else wa++;
        end
        if (!gb && !mul_b_ack && mul_b_stb) begin
          if (wb >= mul_db) begin mul_b_ack = 1; wb = 0; end else wb++;
        end
        if (ga && gb && !mul_z_stb) begin
          if (wz >= mul_dz) begin mul_z = fmul(ra, rb); mul_z_stb = 1; end else wz++;
        end
      end
      pa_stb = mul_a_stb; pb_stb = mul_b_stb; pa = mul_a; pb = mul_b; pz_ack = mul_z_ack;
    end
  end

  initial begin : add_core
    logic pa_stb, pb_stb, pz_ack, ga, gb;
    logic [31:0] pa, pb, ra, rb;
    int wa, wb, wz;
    add_a_ack = 0; add_b_ack = 0; add_z_stb = 0; add_z = 0;
    pa_stb = 0; pb_stb = 0; pz_ack = 0; ga = 0; gb = 0;
    pa = 0; pb = 0; ra = 0; rb = 0; wa = 0; wb = 0; wz = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        add_a_ack = 0; add_b_ack = 0; add_z_stb = 0; ga = 0; gb = 0; wa = 0; wb = 0; wz = 0;
      end else begin
        if (add_a_ack && pa_stb) begin add_a_ack = 0; ga = 1; ra = pa; end
        if (add_b_ack && pb_stb) begin add_b_ack = 0; gb = 1; rb = pb; end
        if (add_z_stb && pz_ack) begin add_z_stb = 0; ga = 0; gb = 0; wz = 0; end
        if (!ga && !add_a_ack && add_a_stb) begin
          if (wa >= add_da) begin add_a_ack = 1; wa = 0; end else wa++;
        end
        if (!gb && !add_b_ack && add_b_stb) begin
          if (wb >= add_db) begin add_b_ack = 1; wb = 0; end else wb++;
        end
        if (ga && gb && !add_z_stb) begin
          if (wz >= add_dz) begin add_z = fadd(ra, rb); add_z_stb = 1; end else wz++;
        end
      end
      pa_stb = add_a_stb; pb_stb = add_b_stb; pa = add_a; pb = add_b; pz_ack = add_z_ack;
    end
  end

  initial begin : monitor
    logic pa, pb, po;
    pa = 0; pb = 0; po = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pa && !mul_a_stb) a_fall = cyc;
      if (pb && !mul_b_stb) b_fall = cyc;
      if (!po && out_z_stb) n_pulse++;
      pa = mul_a_stb; pb = mul_b_stb; po = out_z_stb;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit last);
    int t;
    in_a = a; in_b = b; in_last = last; in_stb = 1'b1;
    t = 0;
    while (!in_ack && t < 300) begin @(negedge clk); t++; end
    if (!in_ack) check("send_timeout", in_ack, 1);
    @(negedge clk);
    in_stb = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [31:0] ez, input int ec);
    int t;
    t = 0;
    while (!out_z_stb && t < 600) begin @(negedge clk); t++; end
    check({tag, "_stb"}, out_z_stb, 1);
    check({tag, "_z"}, out_z, ez);
    check({tag, "_cnt"}, out_cnt, 64'(ec));
    out_z_ack = 1'b1;
    @(negedge clk);
    out_z_ack = 1'b0;
    check({tag, "_drop"}, out_z_stb, 0);
    check({tag, "_pulses"}, 64'(n_pulse - pulse_mark), 1);
    pulse_mark = n_pulse;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    int t, stable, inack_seen, stb_seen, f0;
    rst = 1'b1; in_a = 0; in_b = 0; in_last = 0; in_stb = 0; out_z_ack = 0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {in_ack, mul_a_stb, mul_b_stb, mul_z_ack, add_a_stb, add_b_stb,
                       add_z_ack, out_z_stb}, 0);
    check("rst_out_z", out_z, 0);
    check("rst_out_cnt", out_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    send(32'h414570A4, 32'h42631EB8, 1);
    get_result("single", 32'h442F2A93, 1);

    send(32'h3F800000, 32'h40000000, 0);
    send(32'h40400000, 32'h40800000, 1);
    get_result("two", 32'h41600000, 2);
    send(32'h3F800000, 32'h40000000, 1);
    get_result("restart", 32'h40000000, 1);

    send(32'hBF800000, 32'h40000000, 1);
`ifdef FPU_MAC_RELU_EN
    get_result("neg", 32'h00000000, 1);
`else
    get_result("neg", 32'hC0000000, 1);
`endif

    mul_db = 3;
    f0 = n_mul_fetch;
    send(32'h3FC00000, 32'h40000000, 1);
    get_result("skew", 32'h40400000, 1);
    check("skew_a_first", a_fall < b_fall, 1);
    check("skew_gap", 64'(b_fall - a_fall), 3);
    check("skew_fetches", 64'(n_mul_fetch - f0), 1);
    mul_db = 0;

    send(32'h40400000, 32'h40800000, 1);
    t = 0;
    while (!out_z_stb && t < 600) begin @(negedge clk); t++; end
    in_a = 32'h3F800000; in_b = 32'h40000000; in_last = 1'b1; in_stb = 1'b1;
    stable = 0; inack_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_z_stb && out_z == 32'h41400000 && out_cnt == 1) stable++;
      if (in_ack) inack_seen++;
    end
    check("bp_stable", 64'(stable), 20);
    check("bp_in_ack", 64'(inack_seen), 0);
    get_result("bp", 32'h41400000, 1);
    send(32'h3F800000, 32'h40000000, 1);
    get_result("bp_next", 32'h40000000, 1);

    add_dz = 4;
    send(32'h40400000, 32'h40400000, 1);
    t = 0;
    while (!add_z_ack && t < 300) begin @(negedge clk); t++; end
    check("rst_reach_add_get", add_z_ack, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ctrl", {in_ack, mul_a_stb, mul_b_stb, mul_z_ack, add_a_stb, add_b_stb,
                          add_z_ack, out_z_stb}, 0);
    check("midrst_out_z", out_z, 0);
    check("midrst_out_cnt", out_cnt, 0);
    add_dz = 0;
    stb_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_z_stb) stb_seen++;
    end
    check("midrst_no_out", 64'(stb_seen), 0);
    pulse_mark = n_pulse;
    send(32'h3F800000, 32'h40000000, 1);
    get_result("after_rst", 32'h40000000, 1);

    for (int v = 0; v < 12; v++) begin
      int len;
      len = $urandom_range(1, 5);
      mul_da = $urandom_range(0, 3); mul_db = $urandom_range(0, 3); mul_dz = $urandom_range(0, 3);
      add_da = $urandom_range(0, 3); add_db = $urandom_range(0, 3); add_dz = $urandom_range(0, 3);
      qa.delete(); qb.delete();
      for (int i = 0; i < len; i++) begin
        qa.push_back(rnd_f());
        qb.push_back(rnd_f());
      end
      for (int i = 0; i < len; i++) send(qa[i], qb[i], i == len - 1);
      get_result($sformatf("rnd%0d", v), ref_dot(qa, qb), len);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fpu_mac_seq.md
Name: fpu_mac_seq

Overview:
- Multiply-accumulate sequencer placed directly upstream of the existing adder and multiplier cores.
- Accepts a stream of (a, b) float32 pairs over a stb/ack handshake.
- Issues each pair to the multiplier, then feeds the product plus the running accumulator to the adder.
- On the element flagged last, presents the dot product to the downstream neuron logic.

Parameters:
CNT_W, 16, width of the element counter reported with each result.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_a  input  32  float32 operand A
in_b  input  32  float32 operand B
in_last  input  1  pair is final element of the vector
in_stb  input  1  pair valid
in_ack  output  1  pair accepted
mul_a  output  32  operand to multiplier input_a
mul_b  output  32  operand to multiplier input_b
mul_a_stb  output  1  multiplier input_a_stb
mul_b_stb  output  1  multiplier input_b_stb
mul_a_ack  input  1  multiplier input_a_ack
mul_b_ack  input  1  multiplier input_b_ack
mul_z  input  32  multiplier output_z
mul_z_stb  input  1  multiplier output_z_stb
mul_z_ack  output  1  multiplier output_z_ack
add_a  output  32  accumulator to adder input_a
add_b  output  32  product to adder input_b
add_a_stb  output  1  adder input_a_stb
add_b_stb  output  1  adder input_b_stb
add_a_ack  input  1  adder input_a_ack
add_b_ack  input  1  adder input_b_ack
add_z  input  32  adder output_z
add_z_stb  input  1  adder output_z_stb
add_z_ack  output  1  adder output_z_ack
out_z  output  32  dot-product result
out_cnt  output  CNT_W  number of elements in result
out_z_stb  output  1  result valid
out_z_ack  input  1  result consumed

Behaviour:
- Handshake (all channels): a transfer occurs on a rising clk edge where stb and ack are both high.
  - Master holds stb and data stable until that edge.
  - Master drops stb in the following cycle; it never drops stb early.
- Reset: synchronous, active-high, and same rst as the FPU cores.
  - All stb and ack outputs go to 0, out_z=0, out_cnt=0, accumulator=0x00000000, state=GET_IN.
  - Reset mid-operation abandons the vector with no partial output.
- Registered outputs only; no combinational path from any input to any output.
- State machine:
  - GET_IN: in_ack=1. On in_stb&&in_ack, latch a, b and last, set in_ack=0, go to MUL_PUT.
  - MUL_PUT: mul_a_stb and mul_b_stb start at 1. Each drops independently on its own ack; the done-flags are sticky. When both are done, go to MUL_GET.
  - MUL_GET: mul_z_ack=1. On mul_z_stb&&mul_z_ack, latch the product, set mul_z_ack=0, go to ADD_PUT.
  - ADD_PUT: add_a=accumulator, add_b=product. Same independent a/b ack tracking as MUL_PUT, then go to ADD_GET.
  - ADD_GET: add_z_ack=1. On transfer, accumulator<=add_z and cnt<=cnt+1 (wraps mod 2^CNT_W). Go to PUT_OUT if last was latched, else GET_IN.
  - PUT_OUT: out_z=accumulator, out_cnt=cnt, out_z_stb=1. On out_z_ack, drop stb, clear accumulator to 0x00000000 and cnt to 0, go to GET_IN.
- Only one element is in flight at a time; no new pair is accepted until the current add completes. This is deliberate because the cores are non-pipelined.
- First element computes +0 + p, giving p exactly, including p = -0 → +0 per adder rules.
- Backpressure: with out_z_stb high and out_z_ack low, hold indefinitely; in_ack stays 0.
- Arithmetic (rounding, NaN, inf) is fully delegated to the cores; this block never inspects operand bits except under the optional feature.

Optional Feature:
- Macro FPU_MAC_RELU_EN.
- Defined: in PUT_OUT, out_z = 0x00000000 when accumulator bit31=1, else the accumulator; out_cnt is unchanged.
  - NaN with the sign bit set also yields 0.
- Undefined: out_z equals the accumulator unmodified.
- No port or latency difference between the two builds.

Test Plan:
- Single pair 0x414570A4 × 0x42631EB8, last=1, with real cores → out_z=0x442F2A93, out_cnt=1, one out_z_stb pulse.
- Pairs (0x3F800000,0x40000000),(0x40400000,0x40800000), last on the second → out_z=0x41600000 (14.0), out_cnt=2; the accumulator restarts at 0 for the next vector.
- Pair (0xBF800000,0x40000000), last=1 → out_z=0xC0000000 without FPU_MAC_RELU_EN, 0x00000000 with it.
- Stub cores with mul_b_ack arriving 3 cycles after mul_a_ack → mul_a_stb drops first, mul_b_stb later, a single product fetch, correct result.
- Hold out_z_ack low for 20 cycles → out_z_stb and out_z stay stable, in_ack stays 0. Ack → next vector is accepted.
- Assert rst for 1 cycle while in ADD_GET → all stb/ack outputs 0 next cycle, no out_z_stb. The following vector (1.0×2.0, last) gives 0x40000000, out_cnt=1.
